parking_lot_ctrl: RTL and testbench

//   Occupancy controller for a single-lane car-park gate with two optical

---
 rtl/parking_lot_ctrl.sv | 146 ++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Car-park gate occupancy controller: decodes the a/b sensor occlusion order
// into entry/exit events and keeps a saturating occupancy count.
module parking_lot_ctrl #(
  parameter int CAPACITY = 16,
  parameter int W        = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a,
  input  logic         b,
  output logic         enter_tick,
  output logic         exit_tick,
  output logic         ovf_tick,
  output logic         unf_tick,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  localparam logic [W-1:0] CAP_W = W'(CAPACITY);

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         enter_tick_q, enter_tick_d;
  logic         exit_tick_q, exit_tick_d;
  logic         ovf_tick_q, ovf_tick_d;
  logic         unf_tick_q, unf_tick_d;
  logic [1:0]   ab;

  assign ab = {a, b};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    enter_tick_d = 1'b0;
    exit_tick_d  = 1'b0;
    ovf_tick_d   = 1'b0;
    unf_tick_d   = 1'b0;
    case (state_q)
      // Both beams blocked from IDLE is ambiguous, so it is ignored.
      IDLE: begin
        case (ab)
          2'b10:   state_d = EN1;
          2'b01:   state_d = EX1;
          default: ;
        endcase
      end
      EN1: begin
        case (ab)
          2'b11:   state_d = EN2;
          2'b00,
          2'b01:   state_d = IDLE;
          default: ;
        endcase
      end
      EN2: begin
        case (ab)
          2'b01:   state_d = EN3;
          2'b10:   state_d = EN1;
          2'b00:   state_d = IDLE;
          default: ;
        endcase
      end
      EN3: begin
        case (ab)
          2'b00: begin
            state_d      = IDLE;
            enter_tick_d = 1'b1;
            if (count_q < CAP_W) count_d = count_q + 1'b1;
            else                 ovf_tick_d = 1'b1;
          end
          2'b11:   state_d = EN2;
          2'b10:   state_d = IDLE;
          default: ;
        endcase
      end
      EX1: begin
        case (ab)
          2'b11:   state_d = EX2;
          2'b00,
          2'b10:   state_d = IDLE;
          default: ;
        endcase
      end
      EX2: begin
        case (ab)
          2'b10:   state_d = EX3;
          2'b01:   state_d = EX1;
          2'b00:   state_d = IDLE;
          default: ;
        endcase
      end
      EX3: begin
        case (ab)
          2'b00: begin
            state_d     = IDLE;
            exit_tick_d = 1'b1;
            if (count_q != '0) count_d = count_q - 1'b1;
            else               unf_tick_d = 1'b1;
          end
          2'b11:   state_d = EX2;
          2'b01:   state_d = IDLE;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      enter_tick_q <= 1'b0;
      exit_tick_q  <= 1'b0;
      ovf_tick_q   <= 1'b0;
      unf_tick_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      enter_tick_q <= enter_tick_d;
      exit_tick_q  <= exit_tick_d;
      ovf_tick_q   <= ovf_tick_d;
      unf_tick_q   <= unf_tick_d;
    end
  end

  assign enter_tick = enter_tick_q;
  assign exit_tick  = exit_tick_q;
  assign ovf_tick   = ovf_tick_q;
  assign unf_tick   = unf_tick_q;
  assign count      = count_q;
  assign full       = (count_q == CAP_W);
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl: a sequence-decoder model pushes
// expected outputs into a queue that is popped after each clock edge.
module tb_parking_lot_ctrl;

  localparam int CAPACITY = 16;
  localparam int W        = 5;

  typedef struct packed {
    logic         en;
    logic         ex;
    logic         ov;
    logic         un;
    logic [W-1:0] cnt;
    logic         fu;
    logic         em;
  } exp_t;

  localparam int M_IDLE = 0, M_EN1 = 1, M_EN2 = 2, M_EN3 = 3,
                 M_EX1 = 4, M_EX2 = 5, M_EX3 = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         enter_tick, exit_tick, ovf_tick, unf_tick, full, empty;
  logic [W-1:0] count;

  exp_t sb_q[$];
  int   m_state = M_IDLE;
  int   m_count = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0] entry_seq [4];
  logic [1:0] exit_seq  [4];

  parking_lot_ctrl #(.CAPACITY(CAPACITY), .W(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter_tick(enter_tick), .exit_tick(exit_tick),
    .ovf_tick(ovf_tick), .unf_tick(unf_tick),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(logic en, logic ex, logic ov, logic un);
    exp_t e;
    e.en  = en; e.ex = ex; e.ov = ov; e.un = un;
    e.cnt = W'(m_count);
    e.fu  = (m_count == CAPACITY);
    e.em  = (m_count == 0);
    return e;
  endfunction

  // Behavioural model of the gate decoder; returns outputs after this edge.
  function automatic exp_t model_step(logic [1:0] ab);
    logic en = 0, ex = 0, ov = 0, un = 0;
    int nxt = m_state;
    case (m_state)
      M_IDLE: if (ab == 2'b10) nxt = M_EN1; else if (ab == 2'b01) nxt = M_EX1;
      M_EN1:  if (ab == 2'b11) nxt = M_EN2; else if (ab != 2'b10) nxt = M_IDLE;
      M_EN2:  if (ab == 2'b01) nxt = M_EN3; else if (ab == 2'b10) nxt = M_EN1;
              else if (ab == 2'b00) nxt = M_IDLE;
      M_EN3:  if (ab == 2'b11) nxt = M_EN2; else if (ab == 2'b10) nxt = M_IDLE;
              else if (ab == 2'b00) begin
                nxt = M_IDLE; en = 1;
                if (m_count < CAPACITY) m_count++; else ov = 1;
              end
      M_EX1:  if (ab == 2'b11) nxt = M_EX2; else if (ab != 2'b01) nxt = M_IDLE;
      M_EX2:  if (ab == 2'b10) nxt = M_EX3; else if (ab == 2'b01) nxt = M_EX1;
              else if (ab == 2'b00) nxt = M_IDLE;
      M_EX3:  if (ab == 2'b11) nxt = M_EX2; else if (ab == 2'b01) nxt = M_IDLE;
              else if (ab == 2'b00) begin
                nxt = M_IDLE; ex = 1;
                if (m_count > 0) m_count--; else un = 1;
              end
      default: nxt = M_IDLE;
    endcase
    m_state = nxt;
    return mk_exp(en, ex, ov, un);
  endfunction

  function automatic exp_t dut_obs();
    exp_t o;
    o.en = enter_tick; o.ex = exit_tick; o.ov = ovf_tick; o.un = unf_tick;
    o.cnt = count; o.fu = full; o.em = empty;
    return o;
  endfunction

  task automatic drive(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b0;
    a = ab[1];
    b = ab[0];
    sb_q.push_back(model_step(ab));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1;
    a = ab[1];
    b = ab[0];
    m_state = M_IDLE;
    m_count = 0;
    sb_q.push_back(mk_exp(0, 0, 0, 0));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset(2'b00);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_obs() !== e) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b want %b", dut_obs(), e);
    end
    n_checks++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
    end
  endtask

  task automatic test_entry();
    logic [1:0] seq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    exp_t e;
    int en_seen = 0, ex_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(seq[i/2]);
      e = sb_q.pop_front();
      en_seen += enter_tick;
      ex_seen += exit_tick;
      n_checks++;
      if (dut_obs() !== e) begin
        n_fail++;
        $display("[TB] FAIL entry_step%0d: got %b want %b", i, dut_obs(), e);
      end
    end
    n_checks++;
    if (en_seen != 1 || ex_seen != 0 || count !== 1 || empty !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL entry_summary: enters=%0d exits=%0d count=%0d empty=%b want 1/0/1/0",
               en_seen, ex_seen, count, empty);
    end
  endtask

  task automatic test_exit();
    exp_t e;
    int ex_seen = 0, ou_seen = 0;
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        drive(entry_seq[i]);
        e = sb_q.pop_front();
        n_checks++;
        if (dut_obs() !== e) begin
          n_fail++;
          $display("[TB] FAIL exit_prefill: got %b want %b", dut_obs(), e);
        end
      end
    n_checks++;
    if (count !== 3) begin
      n_fail++;
      $display("[TB] FAIL exit_start_count: got %0d want 3", count);
    end
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      ex_seen += exit_tick;
      ou_seen += ovf_tick + unf_tick;
      n_checks++;
      if (dut_obs() !== e) begin
        n_fail++;
        $display("[TB] FAIL exit_step%0d: got %b want %b", i, dut_obs(), e);
      end
    end
    n_checks++;
    if (ex_seen != 1 || ou_seen != 0 || count !== 2) begin
      n_fail++;
      $display("[TB] FAIL exit_summary: exits=%0d ovf+unf=%0d count=%0d want 1/0/2", ex_seen, ou_seen, count);
    end
  endtask

  task automatic test_abort();
    logic [1:0] seq [10] = '{2'b10, 2'b11, 2'b10, 2'b00,
                             2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    exp_t e;
    int ticks = 0;
    for (int i = 0; i < 10; i++) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      ticks += enter_tick + exit_tick + ovf_tick + unf_tick;
      n_checks++;
      if (dut_obs() !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_step%0d: got %b want %b", i, dut_obs(), e);
      end
    end
    n_checks++;
    if (ticks != 0 || count !== 2) begin
      n_fail++;
      $display("[TB] FAIL abort_summary: ticks=%0d count=%0d want 0/2", ticks, count);
    end
    // Decoder should be back in IDLE: a fresh full entry must register.
    for (int i = 0; i < 4; i++) begin
      drive(entry_seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (dut_obs() !== e) begin
        n_fail++;
        $display("[TB] FAIL abort_reentry%0d: got %b want %b", i, dut_obs(), e);
      end
    end
    n_checks++;
    if (count !== 3) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: count=%0d want 3", count);
    end
  endtask

  task automatic test_full_ovf();
    exp_t e;
    do_reset(2'b00);
    void'(sb_q.pop_front());
    for (int car = 1; car <= CAPACITY + 1; car++) begin
      for (int i = 0; i < 4; i++) begin
        drive(entry_seq[i]);
        e = sb_q.pop_front();
        n_checks++;
        if (dut_obs() !== e) begin
          n_fail++;
          $display("[TB] FAIL full_car%0d_step%0d: got %b want %b", car, i, dut_obs(), e);
        end
      end
      if (car == CAPACITY) begin
        n_checks++;
        if (full !== 1'b1 || count !== 16 || ovf_tick !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL full_flag: full=%b count=%0d ovf=%b want 1/16/0", full, count, ovf_tick);
        end
      end
    end
    n_checks++;
    if (enter_tick !== 1'b1 || ovf_tick !== 1'b1 || count !== 16 || full !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow: enter=%b ovf=%b count=%0d full=%b want 1/1/16/1",
               enter_tick, ovf_tick, count, full);
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    do_reset(2'b00);
    void'(sb_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(exit_seq[i]);
      e = sb_q.pop_front();
      n_checks++;
      if (dut_obs() !== e) begin
        n_fail++;
        $display("[TB] FAIL unf_step%0d: got %b want %b", i, dut_obs(), e);
      end
    end
    n_checks++;
    if (exit_tick !== 1'b1 || unf_tick !== 1'b1 || count !== 0 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL underflow: exit=%b unf=%b count=%0d empty=%b want 1/1/0/1",
               exit_tick, unf_tick, count, empty);
    end
  endtask

  task automatic test_reset_mid_seq();
    exp_t e;
    int en_seen = 0;
    do_reset(2'b00);
    void'(sb_q.pop_front());
    for (int car = 0; car < 5; car++)
      for (int i = 0; i < 4; i++) begin
        drive(entry_seq[i]);
        void'(sb_q.pop_front());
      end
    drive(2'b10);
    void'(sb_q.pop_front());
    drive(2'b11);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_obs() !== e || count !== 5) begin
      n_fail++;
      $display("[TB] FAIL midseq_pre: got %b want %b (count 5)", dut_obs(), e);
    end
    do_reset(2'b11);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_obs() !== e || count !== 0 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midseq_reset: got %b want %b", dut_obs(), e);
    end
    drive(2'b01);
    en_seen += enter_tick;
    void'(sb_q.pop_front());
    drive(2'b00);
    en_seen += enter_tick;
    e = sb_q.pop_front();
    drive(2'b00);
    en_seen += enter_tick;
    void'(sb_q.pop_front());
    n_checks++;
    if (en_seen != 0 || count !== 0) begin
      n_fail++;
      $display("[TB] FAIL midseq_discard: enters=%0d count=%0d want 0/0", en_seen, count);
    end
  endtask

  initial begin
    entry_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    exit_seq  = '{2'b01, 2'b11, 2'b10, 2'b00};
    test_reset();
    test_entry();
    test_exit();
    test_abort();
    test_full_ovf();
    test_underflow();
    test_reset_mid_seq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
